alu_operand_ctrl: RTL

// - Upstream sequencer and downstream result register for the 4-bit ALU.
// - Collects A, B and the op select from shared switches, one press of the enter button per field.
// - Drives the ALU inputs and captures R, Cout and ovr into a flag register.
// - Sits between the board switches/button and the ALU plus its 7-segment display.

---
 rtl/alu_operand_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_operand_ctrl.sv
// Operand sequencer and result/flag register for the 4-bit ALU board.
// Define ACC_CHAIN_EN to feed each result back into A (accumulator mode).
module alu_operand_ctrl #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [1:0]       sw_op,
  input  logic             enter,
  input  logic [WIDTH-1:0] alu_R,
  input  logic             alu_Cout,
  input  logic             alu_ovr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             S0,
  output logic             S1,
  output logic [WIDTH-1:0] result_q,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag,
  output logic             result_valid,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state_q, state_n;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [SYNC_STAGES-1:0] settle;
  logic                   sync_d;
  logic                   ent;
  logic                   load_a, load_b, load_op, capture;
`ifdef ACC_CHAIN_EN
  logic                   chain_a;
`endif

  // Until the chain has refilled after reset, the edge flop is held high so
  // a button still down at reset release cannot look like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      settle  <= '0;
      sync_d  <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], enter};
      settle  <= {settle[SYNC_STAGES-2:0], 1'b1};
      sync_d  <= settle[SYNC_STAGES-1] ? sync_ff[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign ent = sync_ff[SYNC_STAGES-1] & ~sync_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD_A;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    capture = 1'b0;
`ifdef ACC_CHAIN_EN
    chain_a = 1'b0;
`endif
    case (state_q)
      LOAD_A: if (ent) begin
        load_a  = 1'b1;
        state_n = LOAD_B;
      end
      LOAD_B: if (ent) begin
        load_b  = 1'b1;
        state_n = LOAD_OP;
      end
      LOAD_OP: if (ent) begin
        load_op = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_n = DONE;
      end
      DONE: if (ent) begin
`ifdef ACC_CHAIN_EN
        chain_a = 1'b1;
        state_n = LOAD_B;
`else
        state_n = LOAD_A;
`endif
      end
      default: state_n = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A        <= '0;
      B        <= '0;
      S0       <= 1'b0;
      S1       <= 1'b0;
      result_q <= '0;
      c_flag   <= 1'b0;
      v_flag   <= 1'b0;
      z_flag   <= 1'b0;
    end else begin
      if (load_a) A <= sw_data;
`ifdef ACC_CHAIN_EN
      else if (chain_a) A <= result_q;
`endif
      if (load_b) B <= sw_data;
      if (load_op) begin
        S0 <= sw_op[0];
        S1 <= sw_op[1];
      end
      if (capture) begin
        result_q <= alu_R;
        c_flag   <= alu_Cout;
        v_flag   <= alu_ovr;
        z_flag   <= (alu_R == '0);
      end
    end
  end

  assign result_valid = (state_q == DONE);
  assign state        = state_q;

endmodule
